// File: rtl/dac_serializer.sv
// Left-justified stereo DAC serializer: a one-deep holding buffer feeds a frame
// register that is driven MSB-first onto DACDAT on the falling edge of BCLK.
module dac_serializer #(
  parameter int SAMPLE_WIDTH    = 16,
  parameter int UNDERRUN_REPEAT = 0,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                      BCLK,
  input  logic                      RESET,
  input  logic                      DACLRCK,
  input  logic [2*SAMPLE_WIDTH-1:0] DACDAT_PAR,
  input  logic                      VALID,
  output logic                      READY,
  output logic                      DACDAT,
  output logic                      UNDERRUN,
  output logic [CNT_WIDTH-1:0]      UNDERRUN_CNT,
  output logic [2:0]                dbg_state
);

  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int BW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(SAMPLE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEFT  = 3'd1,
    S_LPAD  = 3'd2,
    S_RIGHT = 3'd3,
    S_RPAD  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]         shift_q, shift_d;
  logic [FW-1:0]         last_q, last_d;
  logic [FW-1:0]         buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  lrck_prev_q, lrck_prev_d;
  logic                  dacdat_q, dacdat_d;
  logic                  underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  frame_start;
  logic                  lr_switch;
  logic                  last_bit;
  logic                  accept;
  logic [FW-1:0]         frame_src;
  logic [BW-1:0]         bit_idx;
  logic [SAMPLE_WIDTH-1:0] left_half;
  logic [SAMPLE_WIDTH-1:0] right_half;

  // Handshake: a frame is taken on any falling edge where VALID and READY are
  // both high; READY is simply the inverse of the buffer-full flag.
  assign READY        = ~buf_full_q;
  assign DACDAT       = dacdat_q;
  assign UNDERRUN     = underrun_q;
  assign UNDERRUN_CNT = cnt_q;
  assign dbg_state    = state_q;

  assign frame_start = DACLRCK & ~lrck_prev_q;
  assign lr_switch   = ~DACLRCK & lrck_prev_q;
  assign last_bit    = (bit_cnt_q == LAST_BIT);
  assign accept      = VALID & ~buf_full_q;
  assign bit_idx     = LAST_BIT - bit_cnt_q;
  assign left_half   = shift_q[FW-1:SAMPLE_WIDTH];
  assign right_half  = shift_q[SAMPLE_WIDTH-1:0];

  // An empty buffer at frame start sends silence or repeats the last real frame.
  always_comb begin
    frame_src = '0;
    if (buf_full_q) begin
      frame_src = buf_q;
    end else if (UNDERRUN_REPEAT != 0) begin
      frame_src = last_q;
    end
  end

  always_ff @(negedge BCLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // A frame start always restarts the left half, truncating whatever was in flight.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    if (frame_start) begin
      state_d   = S_LEFT;
      bit_cnt_d = BW'(1);
    end else if (lr_switch && (state_q == S_LEFT || state_q == S_LPAD)) begin
      state_d   = S_RIGHT;
      bit_cnt_d = BW'(1);
    end else begin
      case (state_q)
        S_LEFT: begin
          if (last_bit) begin
            state_d = S_LPAD;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        S_RIGHT: begin
          if (last_bit) begin
            state_d = S_RPAD;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    dacdat_d    = 1'b0;
    shift_d     = shift_q;
    last_d      = last_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    underrun_d  = 1'b0;
    cnt_d       = cnt_q;
    lrck_prev_d = DACLRCK;

    if (frame_start) begin
      shift_d  = frame_src;
      dacdat_d = frame_src[FW-1];
      if (buf_full_q) begin
        last_d     = buf_q;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end else if (lr_switch && (state_q == S_LEFT || state_q == S_LPAD)) begin
      dacdat_d = right_half[SAMPLE_WIDTH-1];
    end else begin
      case (state_q)
        S_LEFT:  dacdat_d = left_half[bit_idx];
        S_RIGHT: dacdat_d = right_half[bit_idx];
        default: dacdat_d = 1'b0;
      endcase
    end

    // Capture happens after the frame-start load, so a word accepted on the
    // frame-start edge waits for the next frame instead of bypassing.
    if (accept) begin
      buf_d      = DACDAT_PAR;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(negedge BCLK or posedge RESET) begin
    if (RESET) begin
      shift_q     <= '0;
      last_q      <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      lrck_prev_q <= 1'b1;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      shift_q     <= shift_d;
      last_q      <= last_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      lrck_prev_q <= lrck_prev_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
